// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding
// and the default stall-watchdog limit.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam int unsigned WB_ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_arb_rr2.sv
// Round-robin grant decision for two requesters: on a tie the master that
// did not own the bus last is chosen.
module wb_arb_rr2
   import wb_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       next_owner,
   output logic       valid
);

   always_comb begin
      valid      = |req;
      next_owner = (req == 2'b11) ? ~last_owner : req[1];
   end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone arbiter, round-robin and cyc-granular.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2
   import wb_arb_pkg::*;
#(
   parameter int unsigned adr_width      = 32,
   parameter int unsigned dat_width      = 32,
   parameter int unsigned timeout_cycles = WB_ARB_TIMEOUT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic [adr_width-1:0]   m0_adr_i,
   input  logic [dat_width-1:0]   m0_dat_i,
   output logic [dat_width-1:0]   m0_dat_o,
   input  logic [dat_width/8-1:0] m0_sel_i,
   input  logic                   m0_we_i,
   input  logic                   m0_cyc_i,
   input  logic                   m0_stb_i,
   output logic                   m0_ack_o,
   output logic                   m0_err_o,

   input  logic [adr_width-1:0]   m1_adr_i,
   input  logic [dat_width-1:0]   m1_dat_i,
   output logic [dat_width-1:0]   m1_dat_o,
   input  logic [dat_width/8-1:0] m1_sel_i,
   input  logic                   m1_we_i,
   input  logic                   m1_cyc_i,
   input  logic                   m1_stb_i,
   output logic                   m1_ack_o,
   output logic                   m1_err_o,

   output logic [adr_width-1:0]   s_adr_o,
   output logic [dat_width-1:0]   s_dat_o,
   output logic [dat_width/8-1:0] s_sel_o,
   output logic                   s_we_o,
   output logic                   s_cyc_o,
   output logic                   s_stb_o,
   input  logic [dat_width-1:0]   s_dat_i,
   input  logic                   s_ack_i,
   input  logic                   s_err_i
);

   arb_state_e state_q, state_d;
   logic       last_owner_q, last_owner_d;
   logic       rr_next, rr_valid;
   logic       timeout_hit;

   wb_arb_rr2 u_rr (
      .req        ({m1_cyc_i, m0_cyc_i}),
      .last_owner (last_owner_q),
      .next_owner (rr_next),
      .valid      (rr_valid)
   );

   // On release the owner's cyc is already low, so the arbiter only ever
   // sees the other master's request and hands over without an idle cycle.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      case (state_q)
         IDLE: begin
            if (rr_valid) state_d = rr_next ? OWN1 : OWN0;
         end
         OWN0: begin
            if (!m0_cyc_i) begin
               last_owner_d = 1'b0;
               state_d      = rr_valid ? (rr_next ? OWN1 : OWN0) : IDLE;
            end
         end
         OWN1: begin
            if (!m1_cyc_i) begin
               last_owner_d = 1'b1;
               state_d      = rr_valid ? (rr_next ? OWN1 : OWN0) : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(timeout_cycles + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_stb;

   always_comb begin
      case (state_q)
         OWN0:    owner_stb = m0_stb_i;
         OWN1:    owner_stb = m1_stb_i;
         default: owner_stb = 1'b0;
      endcase
      timeout_hit = owner_stb && (cnt_q == CNT_W'(timeout_cycles));
      if ((state_d != state_q) || s_ack_i || s_err_i || timeout_hit)
         cnt_d = '0;
      else if (owner_stb)
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
`ifdef WB_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      case (state_q)
         OWN0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~timeout_hit;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | timeout_hit;
         end
         OWN1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~timeout_hit;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | timeout_hit;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios followed by random
// traffic, all checked against an ownership-level reference model.
module tb_wb_arbiter2;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TO = 8;
   localparam logic [AW-1:0] ADR0 = 32'h0000_00A0;
   localparam logic [AW-1:0] ADR1 = 32'h0000_00B1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [AW-1:0] adr  [2];
   logic [DW-1:0] wdat [2];
   logic [SW-1:0] sel  [2];
   logic          we   [2];
   logic          cyc  [2];
   logic          stb  [2];

   logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic [AW-1:0] s_adr_o;
   logic [SW-1:0] s_sel_o;
   logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;

   wb_arbiter2 #(.adr_width(AW), .dat_width(DW), .timeout_cycles(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o), .m0_sel_i(sel[0]),
      .m0_we_i(we[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o), .m1_sel_i(sel[1]),
      .m1_we_i(we[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i)
   );

   always #5 clk = ~clk;

   // Reference model: owner is -1 when the bus is free, else the master index.
   int owner = -1;
   int last  = 1;
   int stall = 0;
   int n_tests = 0;
   int n_fail  = 0;

   bit   log_en = 1'b0;
   logic prev_scyc = 1'b0;
   int   grant_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hit();
`ifdef WB_ARB_TIMEOUT_EN
      if (owner < 0) return 1'b0;
      return stb[owner] && (stall == int'(TO));
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_update();
      int nxt;
      bit hit;
      hit = model_hit();
      if (rst) begin
         owner = -1;
         last  = 1;
         stall = 0;
         return;
      end
      nxt = owner;
      if (owner < 0) begin
         if (cyc[0] && cyc[1]) nxt = 1 - last;
         else if (cyc[0])      nxt = 0;
         else if (cyc[1])      nxt = 1;
      end else if (!cyc[owner]) begin
         last = owner;
         nxt  = cyc[1-owner] ? 1 - owner : -1;
      end
      if (nxt != owner || s_ack_i || s_err_i || hit) stall = 0;
      else if (owner >= 0 && stb[owner])             stall++;
      owner = nxt;
   endtask

   task automatic settle();
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      logic [SW-1:0] e_sel;
      logic          e_we, e_cyc, e_stb;
      bit            hit;
      @(negedge clk);
      hit = model_hit();
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
      if (owner >= 0) begin
         e_adr = adr[owner]; e_dat = wdat[owner]; e_sel = sel[owner];
         e_we  = we[owner];  e_cyc = cyc[owner];  e_stb = stb[owner] & !hit;
      end
      chk("s_adr",  64'(s_adr_o), 64'(e_adr));
      chk("s_dat",  64'(s_dat_o), 64'(e_dat));
      chk("s_sel",  64'(s_sel_o), 64'(e_sel));
      chk("s_we",   64'(s_we_o),  64'(e_we));
      chk("s_cyc",  64'(s_cyc_o), 64'(e_cyc));
      chk("s_stb",  64'(s_stb_o), 64'(e_stb));
      chk("m0_ack", 64'(m0_ack_o), 64'(owner == 0 && s_ack_i));
      chk("m1_ack", 64'(m1_ack_o), 64'(owner == 1 && s_ack_i));
      chk("m0_err", 64'(m0_err_o), 64'(owner == 0 && (s_err_i || hit)));
      chk("m1_err", 64'(m1_err_o), 64'(owner == 1 && (s_err_i || hit)));
      chk("m0_dat", 64'(m0_dat_o), 64'(s_dat_i));
      chk("m1_dat", 64'(m1_dat_o), 64'(s_dat_i));
      if (log_en && s_cyc_o === 1'b1 && prev_scyc !== 1'b1)
         grant_q.push_back((s_adr_o == ADR1) ? 1 : 0);
      prev_scyc = s_cyc_o;
   endtask

   task automatic clock();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      settle();
      clock();
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         adr[i] = '0; wdat[i] = '0; sel[i] = '0; we[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
      end
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
   endtask

   initial begin
      int run [2];
      int prev_owner;
      int errs;
      int err_cyc;
      int exp_order [6];

      idle_inputs();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      step();

      // m0 single read; ack arrives in the same cycle m0 drops cyc
      adr[0] = 32'h4000_0010; sel[0] = '1; cyc[0] = 1'b1; stb[0] = 1'b1;
      settle(); chk("read_lat0_cyc", 64'(s_cyc_o), 64'd0); clock();
      settle(); chk("read_lat1_cyc", 64'(s_cyc_o), 64'd1);
      chk("read_adr", 64'(s_adr_o), 64'h4000_0010); clock();
      step();
      s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; cyc[0] = 1'b0; stb[0] = 1'b0;
      settle();
      chk("read_ack", 64'(m0_ack_o), 64'd1);
      chk("read_data", 64'(m0_dat_o), 64'hDEAD_BEEF);
      chk("read_m1_ack", 64'(m1_ack_o), 64'd0);
      clock();
      idle_inputs();
      settle(); chk("read_released", 64'(s_cyc_o), 64'd0); clock();

      // Both masters request continuously, each holding cyc two owned cycles
      rst = 1'b1; step(); rst = 1'b0;
      adr[0] = ADR0; adr[1] = ADR1;
      run[0] = 0; run[1] = 0;
      s_ack_i = 1'b1;
      log_en = 1'b1; prev_scyc = 1'b0;
      for (int c = 0; c < 60 && grant_q.size() < 6; c++) begin
         for (int i = 0; i < 2; i++) begin
            cyc[i] = !(owner == i && run[i] == 2);
            stb[i] = cyc[i];
         end
         prev_owner = owner;
         step();
         for (int i = 0; i < 2; i++)
            run[i] = (owner == i) ? ((prev_owner == i) ? run[i] + 1 : 0) : 0;
      end
      log_en = 1'b0;
      exp_order = '{0, 1, 0, 1, 0, 1};
      chk("rr_grant_count", 64'(grant_q.size()), 64'd6);
      for (int j = 0; j < 6 && j < grant_q.size(); j++)
         chk($sformatf("rr_grant_%0d", j), 64'(grant_q[j]), 64'(exp_order[j]));
      idle_inputs();
      step(); step();

      // m1 holds the bus over four beats while m0 waits
      adr[0] = ADR0; adr[1] = ADR1;
      cyc[1] = 1'b1; stb[1] = 1'b1;
      step();
      cyc[0] = 1'b1; stb[0] = 1'b1;
      s_ack_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
         settle();
         chk("hold_m0_blocked", 64'(m0_ack_o), 64'd0);
         chk("hold_m1_beat", 64'(m1_ack_o), 64'd1);
         clock();
      end
      s_ack_i = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
      step();
      settle();
      chk("handover_cyc", 64'(s_cyc_o), 64'd1);
      chk("handover_adr", 64'(s_adr_o), 64'(ADR0));
      clock();
      idle_inputs();
      step(); step();

      // Reset while m1 owns and awaits an ack
      adr[0] = ADR0; adr[1] = ADR1;
      cyc[1] = 1'b1; stb[1] = 1'b1;
      step(); step();
      cyc[0] = 1'b1; stb[0] = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0; s_ack_i = 1'b1;
      settle();
      chk("rst_cyc", 64'(s_cyc_o), 64'd0);
      chk("rst_m0_ack", 64'(m0_ack_o), 64'd0);
      chk("rst_m1_ack", 64'(m1_ack_o), 64'd0);
      clock();
      s_ack_i = 1'b0;
      settle();
      chk("rst_tie_cyc", 64'(s_cyc_o), 64'd1);
      chk("rst_tie_m0", 64'(s_adr_o), 64'(ADR0));
      clock();
      idle_inputs();
      step(); step();

      // Slave that never responds: watchdog error (or none without the watchdog)
      adr[0] = ADR0; cyc[0] = 1'b1; stb[0] = 1'b1;
      errs = 0; err_cyc = -1;
      for (int c = 0; c < 30; c++) begin
         settle();
         if (m0_err_o === 1'b1) begin
            errs++;
            if (err_cyc < 0) err_cyc = c;
         end
         clock();
`ifdef WB_ARB_TIMEOUT_EN
         if (errs > 0) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      chk("timeout_err_count", 64'(errs), 64'd1);
      chk("timeout_err_cycle", 64'(err_cyc), 64'(1 + TO));
`else
      chk("no_timeout_err", 64'(errs), 64'd0);
`endif
      idle_inputs();
      step(); step();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < 2; i++) begin
            if (cyc[i]) begin
               if ($urandom_range(0, 3) == 0) cyc[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               cyc[i] = 1'b1;
            end
            stb[i]  = cyc[i] & ($urandom_range(0, 3) != 0);
            adr[i]  = $urandom;
            wdat[i] = $urandom;
            sel[i]  = SW'($urandom);
            we[i]   = $urandom_range(0, 1) == 1;
         end
         s_ack_i = ($urandom_range(0, 2) == 0);
         s_err_i = ($urandom_range(0, 10) == 0);
         s_dat_i = $urandom;
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
